// File: rtl/ext_pipe.sv
// Immediate/data extension stage with a two-entry valid/ready skid buffer.
// The result is extended at the input, stored, and delivered in strict FIFO order.
module ext_pipe #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        ExtOp,
  input  logic [IMM_W-1:0]  Imm,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Ext,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int S = DATA_W - IMM_W;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   main_data, skid_data;
  logic [TAG_W-1:0]    main_tag, skid_tag;
  logic [DATA_W-1:0]   ext_val;
  logic [DATA_W-1:0]   sx, zx;
  logic                accept, pop;
  logic                load_main, load_skid, move_skid;

  assign sx = {{S{Imm[IMM_W-1]}}, Imm};
  assign zx = {{S{1'b0}}, Imm};

  always_comb begin
    ext_val = '0;
    unique case (ExtOp)
      3'b000: ext_val = zx;
      3'b001: ext_val = sx;
      3'b010: ext_val = {Imm, {S{1'b0}}};
      3'b011: ext_val = '0;
      3'b100: ext_val = {sx[DATA_W-3:0], 2'b00};
      3'b101: ext_val = {{(DATA_W-8){Imm[7]}}, Imm[7:0]};
      3'b110: ext_val = {{(DATA_W-8){1'b0}}, Imm[7:0]};
      3'b111: ext_val = {zx[DATA_W-3:0], 2'b00};
      default: ext_val = '0;
    endcase
  end

  // Handshake flags are decodes of the state register only, so no
  // combinational path exists from out_ready or in_valid to any output.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign Ext       = main_data;
  assign out_tag   = main_tag;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_comb begin
    state_n   = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (reset || flush) begin
      state_n = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_n   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_n   = FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_n = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_n   = ONE;
            move_skid = 1'b1;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      main_data <= '0;
      main_tag  <= '0;
      skid_data <= '0;
      skid_tag  <= '0;
    end else begin
      state <= state_n;
      if (load_main) begin
        main_data <= ext_val;
        main_tag  <= in_tag;
      end else if (move_skid) begin
        main_data <= skid_data;
        main_tag  <= skid_tag;
      end
      if (load_skid) begin
        skid_data <= ext_val;
        skid_tag  <= in_tag;
      end
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: vector table, scoreboard and corner-case sequences.
module tb_ext_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [2:0]  ExtOp;
  logic [15:0] Imm;
  logic [4:0]  in_tag, out_tag;
  logic [31:0] Ext;

  logic        reset2, flush2, in_valid2, out_ready2, in_ready2, out_valid2;
  logic [2:0]  ExtOp2;
  logic [11:0] Imm2;
  logic [4:0]  in_tag2, out_tag2;
  logic [23:0] Ext2;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  t;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [2:0]  op;
    logic [15:0] imm;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  ext_pipe dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ExtOp(ExtOp), .Imm(Imm), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .Ext(Ext), .out_tag(out_tag)
  );

  ext_pipe #(.IMM_W(12), .DATA_W(24), .TAG_W(5)) dut2 (
    .clk(clk), .reset(reset2), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
    .ExtOp(ExtOp2), .Imm(Imm2), .in_tag(in_tag2), .out_valid(out_valid2),
    .out_ready(out_ready2), .Ext(Ext2), .out_tag(out_tag2)
  );

  // Arithmetic reference model, independent of the RTL's bit concatenations.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [15:0] imm);
    longint s, b, r;
    s = imm;
    if (imm[15]) s = s - 65536;
    b = imm & 255;
    r = 0;
    case (op)
      3'd0: r = imm;
      3'd1: r = s;
      3'd2: r = longint'(imm) * 65536;
      3'd3: r = 0;
      3'd4: r = s * 4;
      3'd5: r = (b >= 128) ? b - 256 : b;
      3'd6: r = b;
      3'd7: r = longint'(imm) * 4;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, settle, score the handshake, then advance past posedge.
  task automatic step(input logic iv, input logic [2:0] op, input logic [15:0] im,
                      input logic [4:0] tg, input logic ordy, input logic fl, input logic rs);
    sb_t e;
    @(negedge clk);
    in_valid = iv; ExtOp = op; Imm = im; in_tag = tg;
    out_ready = ordy; flush = fl; reset = rs;
    #1;
    if (out_valid === 1'b1 && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {27'd0, out_tag, Ext}, 64'hDEAD);
      end else begin
        e = sb.pop_front();
        chk("sb_data", {32'd0, Ext}, {32'd0, e.d});
        chk("sb_tag", {59'd0, out_tag}, {59'd0, e.t});
      end
    end
    if (reset || flush) sb.delete();
    else if (in_valid && in_ready === 1'b1) sb.push_back('{model(op, im), tg});
    @(posedge clk);
    #1;
  endtask

  logic [31:0] held;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ExtOp = '0; Imm = '0; in_tag = '0;
    reset2 = 1'b1; flush2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1;
    ExtOp2 = '0; Imm2 = '0; in_tag2 = '0;

    vecs[0] = '{3'b000, 16'h8000, 5'd1, 32'h0000_8000};
    vecs[1] = '{3'b001, 16'h8000, 5'd2, 32'hFFFF_8000};
    vecs[2] = '{3'b010, 16'h8000, 5'd3, 32'h8000_0000};
    vecs[3] = '{3'b011, 16'h8000, 5'd4, 32'h0000_0000};
    vecs[4] = '{3'b100, 16'hFFFF, 5'd5, 32'hFFFF_FFFC};
    vecs[5] = '{3'b111, 16'hFFFF, 5'd6, 32'h0003_FFFC};
    vecs[6] = '{3'b101, 16'h0080, 5'd7, 32'hFFFF_FF80};
    vecs[7] = '{3'b110, 16'h0080, 5'd8, 32'h0000_0080};

    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_ext", {32'd0, Ext}, 64'd0);
    chk("rst_tag", {59'd0, out_tag}, 64'd0);

    // Mode sweep: each result visible one cycle after its accept.
    for (int i = 0; i < 8; i++) begin
      step(1, vecs[i].op, vecs[i].imm, vecs[i].tag, 1, 0, 0);
      chk("sweep_valid", {63'd0, out_valid}, 64'd1);
      chk("sweep_ext", {32'd0, Ext}, {32'd0, vecs[i].exp});
      chk("sweep_tag", {59'd0, out_tag}, {59'd0, vecs[i].tag});
    end
    step(0, 0, 0, 0, 1, 0, 0);
    chk("sweep_drained", {63'd0, out_valid}, 64'd0);

    // Back-pressure: tags 1,2 fill the buffer, tag 3 is held off.
    step(1, 3'b001, 16'h1234, 5'd1, 0, 0, 0);
    step(1, 3'b000, 16'hABCD, 5'd2, 0, 0, 0);
    chk("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_full_valid", {63'd0, out_valid}, 64'd1);
    held = Ext;
    chk("bp_head", {32'd0, Ext}, {32'd0, model(3'b001, 16'h1234)});
    for (int i = 0; i < 3; i++) begin
      step(1, 3'b100, 16'h0F0F, 5'd3, 0, 0, 0);
      chk("bp_stall_ext", {32'd0, Ext}, {32'd0, held});
      chk("bp_stall_tag", {59'd0, out_tag}, 64'd1);
      chk("bp_stall_in_ready", {63'd0, in_ready}, 64'd0);
    end
    step(1, 3'b100, 16'h0F0F, 5'd3, 1, 0, 0);
    chk("bp_tag2_next", {59'd0, out_tag}, 64'd2);
    step(1, 3'b100, 16'h0F0F, 5'd3, 1, 0, 0);
    chk("bp_tag3_next", {59'd0, out_tag}, 64'd3);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0);
    chk("bp_no_dup", {63'd0, out_valid}, 64'd0);
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Streaming at full throughput with random operands.
    for (int i = 0; i < 20; i++) begin
      step(1, 3'($urandom_range(0, 7)), 16'($urandom), 5'($urandom), 1, 0, 0);
      chk("stream_valid", {63'd0, out_valid}, 64'd1);
    end
    step(0, 0, 0, 0, 1, 0, 0);
    chk("stream_sb_empty", 64'(sb.size()), 64'd0);

    // Flush while FULL with in_valid high: nothing survives.
    step(1, 3'b000, 16'h0011, 5'd9, 0, 0, 0);
    step(1, 3'b000, 16'h0022, 5'd10, 0, 0, 0);
    step(1, 3'b000, 16'h0033, 5'd11, 0, 1, 0);
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    // Flush in ONE with a real accept: the accepted operand is dropped.
    step(1, 3'b000, 16'h0044, 5'd12, 0, 0, 0);
    step(1, 3'b000, 16'h0055, 5'd13, 0, 1, 0);
    chk("flush_one_valid", {63'd0, out_valid}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, 0, 0);
      chk("flush_never_appears", {63'd0, out_valid}, 64'd0);
    end

    // Reset while FULL and stalled.
    step(1, 3'b001, 16'hFFFF, 5'd20, 0, 0, 0);
    step(1, 3'b001, 16'hFFFE, 5'd21, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("mrst_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst_ext", {32'd0, Ext}, 64'd0);
    chk("mrst_tag", {59'd0, out_tag}, 64'd0);
    chk("mrst_in_ready", {63'd0, in_ready}, 64'd1);
    step(1, 3'b100, 16'h8001, 5'd22, 1, 0, 0);
    chk("mrst_first_valid", {63'd0, out_valid}, 64'd1);
    chk("mrst_first_ext", {32'd0, Ext}, 64'hFFFE_0004);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("mrst_sb_empty", 64'(sb.size()), 64'd0);

    // Narrow parameter variant.
    @(negedge clk); reset2 = 1'b0;
    @(negedge clk); in_valid2 = 1'b1; ExtOp2 = 3'b001; Imm2 = 12'h800; in_tag2 = 5'd7;
    @(posedge clk); #1;
    chk("p2_signed", {40'd0, Ext2}, 64'hFF_F800);
    chk("p2_tag", {59'd0, out_tag2}, 64'd7);
    @(negedge clk); ExtOp2 = 3'b010;
    @(posedge clk); #1;
    chk("p2_lui", {40'd0, Ext2}, 64'h80_0000);
    @(negedge clk); in_valid2 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
